cart_mem_arbiter: RTL and testbench
===================================

Name: cart_mem_arbiter

Overview:
- Shares the single cartridge SDRAM port between two requesters: the SPI ROM loader's write stream and the console's cartridge read port.
- Sits between the loader/console side and the SDRAM controller, replacing direct address/we/rd muxing.
- Buffers loader writes in a small FIFO, because the loader cannot be stalled.
- Deduplicates repeated cart reads, holds read data stable, and flags loader overflow and memory timeouts.

Parameters:
AW, 25, byte address width on both requesters and on the memory side
FIFO_DEPTH, 4, loader write FIFO entries (power of two, >=2)
TIMEOUT, 64, cycles to wait for mem_ack before aborting a memory access

Ports:
clk_i  in  1  system clock (24 MHz domain)
res_n_i  in  1  asynchronous active-low reset
dl_active_i  in  1  ROM download in progress
ld_wr_i  in  1  one-cycle loader write strobe
ld_addr_i  in  AW  loader byte address
ld_data_i  in  8  loader byte
cart_rd_i  in  1  cart read request level
cart_addr_i  in  AW  cart byte address
cart_do_o  out  8  cart read data, held between reads
cart_valid_o  out  1  cart_do_o matches current cart_addr_i
mem_req_o  out  1  one-cycle memory request pulse
mem_we_o  out  1  qualifies mem_req_o: 1=write, 0=read
mem_addr_o  out  AW  memory address
mem_din_o  out  16  write data, byte duplicated on both halves
mem_dout_i  in  16  read data, low byte used
mem_ack_i  in  1  one-cycle completion; read data valid in the same cycle
busy_o  out  1  FIFO non-empty or FSM not IDLE
ovf_o  out  1  sticky loader overflow
tmo_o  out  1  sticky memory timeout

Behaviour:
- Reset values: all outputs 0, except cart_do_o=8'hFF. FIFO empty, FSM in IDLE, last-read tag invalid.
- Loader FIFO push:
  - ld_wr_i pushes {ld_addr_i, ld_data_i}.
  - Push while full drops the byte and sets ovf_o.
  - A simultaneous push and pop on a full FIFO is accepted.
  - Pointers wrap modulo FIFO_DEPTH.
- ovf_o and tmo_o clear only on reset or on a dl_active_i rising edge.
- FSM states: IDLE, WR, RD, WAIT_W, WAIT_R.
- IDLE, priority order:
  - FIFO non-empty -> WR.
  - Otherwise, if cart_rd_i=1 and dl_active_i=0 and (tag invalid or cart_addr_i != tag) -> RD.
  - Otherwise stay in IDLE.
- WR:
  - Drive mem_req_o=1 and mem_we_o=1 for one cycle, with the FIFO head on mem_addr_o and mem_din_o.
  - Pop the head in the same cycle, then go to WAIT_W.
- RD:
  - Drive mem_req_o=1 and mem_we_o=0 for one cycle with mem_addr_o=cart_addr_i.
  - Capture the address into a pending register, then go to WAIT_R.
- WAIT_W: on mem_ack_i -> IDLE.
- WAIT_R: on mem_ack_i, set cart_do_o=mem_dout_i[7:0], set tag=pending address (tag valid), then go to IDLE.
- mem_addr_o and mem_din_o hold their value until the next request.
- Timeout:
  - The counter is cleared on entering WAIT_*.
  - Reaching TIMEOUT-1 with no ack sets tmo_o and returns to IDLE.
  - A timed-out read leaves cart_do_o unchanged and the tag invalid.
  - A timed-out write is lost; no retry.
- cart_valid_o is combinational: tag valid and cart_addr_i==tag and dl_active_i=0.
- Tag invalidation:
  - The tag is invalidated on every accepted FIFO push, and whenever dl_active_i=1.
  - A write that is accepted while a read is in WAIT_R still lets that read complete, but its tag is not set valid.
- Download lockout:
  - While dl_active_i=1, no read starts.
  - After dl_active_i falls, reads are blocked until the FIFO is empty and the FSM is in IDLE. This guarantees the last loaded bytes are committed before the console reads.
- Latency: best-case read is request cycle + ack cycle, so cart_valid_o is high 1 cycle after the ack.
- Ignored inputs: a stray mem_ack_i while in IDLE, WR or RD is ignored.
- Reset mid-operation: async reset returns to IDLE immediately, flushes the FIFO and drops any outstanding request.

Test Plan:
- Reset: assert res_n_i=0 mid WAIT_R -> outputs zero, cart_do_o=FF, busy_o=0 after release.
- Loader burst: dl_active_i=1, 4 writes addr 0..3 data A0..A3, mem_ack_i 3 cycles after each req -> four mem_we_o pulses in order, mem_din_o=16'hA0A0.., ovf_o=0.
- Overflow: FIFO_DEPTH=4, 6 back-to-back ld_wr_i with ack withheld -> ovf_o=1, exactly the first 5 writes issued (1 popped + 4 stored), 6th dropped.
- Cart read and dedup:
  - Read addr 0x0123 returning 16'h005A -> one read req, cart_do_o=5A, cart_valid_o=1.
  - Holding the same address issues no further req.
  - Changing to 0x0124 drops cart_valid_o and issues a new req.
- Priority: FIFO non-empty and cart read pending in IDLE together -> write issued first, read issued after WAIT_W completes; cart_valid_o stays 0 until then.
- Timeout: TIMEOUT=64, read with no ack -> tmo_o=1 at 64 cycles, FSM back to IDLE, cart_do_o unchanged, new read retried.

Source files
------------

// File: rtl/cart_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cart_mem_arbiter
// Purpose  : Shares the cartridge SDRAM port between the SPI ROM loader write
//            stream and the console cartridge read port. Loader writes go
//            into a small FIFO because the loader cannot be stalled. Loader
//            writes win over cart reads. Repeated reads of the same address
//            are absorbed by a one-entry tag, and the last read byte is held.
// Ports    : clk_i/res_n_i             clock, async active-low reset
//            dl_active_i               ROM download in progress
//            ld_wr_i/ld_addr_i/ld_data_i  loader byte write strobe
//            cart_rd_i/cart_addr_i     console read request level + address
//            cart_do_o/cart_valid_o    held read byte, matches cart_addr_i
//            mem_*                     SDRAM controller request/ack port
//            busy_o/ovf_o/tmo_o        activity, sticky overflow, sticky timeout
// Revision : 1.0 - initial release
// ============================================================================
module cart_mem_arbiter #(
  parameter int AW         = 25,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic          clk_i,
  input  logic          res_n_i,
  input  logic          dl_active_i,
  input  logic          ld_wr_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [7:0]    ld_data_i,
  input  logic          cart_rd_i,
  input  logic [AW-1:0] cart_addr_i,
  output logic [7:0]    cart_do_o,
  output logic          cart_valid_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [15:0]   mem_din_o,
  input  logic [15:0]   mem_dout_i,
  input  logic          mem_ack_i,
  output logic          busy_o,
  output logic          ovf_o,
  output logic          tmo_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    RD     = 3'd2,
    WAIT_W = 3'd3,
    WAIT_R = 3'd4
  } state_t;

  state_t          state_q, state_d;

  logic [AW-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [7:0]      fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     cnt_q;

  logic [CW-1:0]   tmo_cnt_q;
  logic [AW-1:0]   tag_q;
  logic            tag_vld_q;
  logic            pend_ok_q;
  logic [7:0]      cart_do_q;
  logic [AW-1:0]   mem_addr_q;
  logic [15:0]     mem_din_q;
  logic            mem_we_q;
  logic            dl_q;
  logic            ovf_q;
  logic            tmo_q;

  logic            fifo_empty, fifo_full;
  logic            pop, push_ok, ovf_evt, dl_rise, cart_hit;
  logic            go_wr, go_rd, rd_done, tmo_evt, rd_tmo, in_wait;
  logic            unused_dout_hi;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FULL_CNT);
  assign pop        = (state_q == WR);
  // A full FIFO still takes a byte in the cycle the head is popped.
  assign push_ok    = ld_wr_i && (!fifo_full || pop);
  assign ovf_evt    = ld_wr_i && fifo_full && !pop;
  assign dl_rise    = dl_active_i && !dl_q;
  assign cart_hit   = tag_vld_q && (cart_addr_i == tag_q);
  assign in_wait    = (state_q == WAIT_W) || (state_q == WAIT_R);
  assign rd_tmo     = tmo_evt && (state_q == WAIT_R);
  assign unused_dout_hi = ^mem_dout_i[15:8];

  // Next-state logic. Reads start only from IDLE with an empty FIFO, which
  // also keeps the console off memory until the last loaded byte is written.
  always_comb begin
    state_d = state_q;
    go_wr   = 1'b0;
    go_rd   = 1'b0;
    rd_done = 1'b0;
    tmo_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          go_wr   = 1'b1;
          state_d = WR;
        end else if (cart_rd_i && !dl_active_i && !cart_hit) begin
          go_rd   = 1'b1;
          state_d = RD;
        end
      end
      WR:     state_d = WAIT_W;
      RD:     state_d = WAIT_R;
      WAIT_W: begin
        if (mem_ack_i) begin
          state_d = IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_evt = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_R: begin
        if (mem_ack_i) begin
          rd_done = 1'b1;
          state_d = IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_evt = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage carries no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      fifo_addr_q[wr_ptr_q] <= ld_addr_i;
      fifo_data_q[wr_ptr_q] <= ld_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      tmo_cnt_q  <= '0;
      tag_q      <= '0;
      tag_vld_q  <= 1'b0;
      pend_ok_q  <= 1'b0;
      cart_do_q  <= 8'hFF;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      dl_q       <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      dl_q    <= dl_active_i;

      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase

      // Counter restarts in the request cycle so the first wait cycle sees 0.
      if (pop || state_q == RD) tmo_cnt_q <= '0;
      else if (in_wait)         tmo_cnt_q <= tmo_cnt_q + 1'b1;

      // Request address/data are latched on the way out of IDLE and then held;
      // mem_addr_q doubles as the pending read address.
      if (go_wr) begin
        mem_we_q   <= 1'b1;
        mem_addr_q <= fifo_addr_q[rd_ptr_q];
        mem_din_q  <= {2{fifo_data_q[rd_ptr_q]}};
      end else if (go_rd) begin
        mem_we_q   <= 1'b0;
        mem_addr_q <= cart_addr_i;
      end

      // pend_ok_q drops if anything could have made the in-flight read stale.
      pend_ok_q <= (go_rd || pend_ok_q) && !(push_ok || dl_active_i);

      if (rd_done) begin
        cart_do_q <= mem_dout_i[7:0];
        tag_q     <= mem_addr_q;
      end
      if (push_ok || dl_active_i || rd_tmo) tag_vld_q <= 1'b0;
      else if (rd_done)                     tag_vld_q <= pend_ok_q;

      // Setting wins over the clearing edge so a same-cycle event is not lost.
      if (ovf_evt)      ovf_q <= 1'b1;
      else if (dl_rise) ovf_q <= 1'b0;
      if (tmo_evt)      tmo_q <= 1'b1;
      else if (dl_rise) tmo_q <= 1'b0;
    end
  end

  assign cart_do_o    = cart_do_q;
  assign cart_valid_o = cart_hit && !dl_active_i;
  assign mem_req_o    = (state_q == WR) || (state_q == RD);
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_din_o    = mem_din_q;
  assign busy_o       = !fifo_empty || (state_q != IDLE);
  assign ovf_o        = ovf_q;
  assign tmo_o        = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_cart_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cart_mem_arbiter
// Purpose  : Self-checking bench for cart_mem_arbiter. A behavioural SDRAM
//            responder logs every request and acks after a chosen latency;
//            expected request streams and read data come from bench-side
//            queues and arrays.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cart_mem_arbiter;
  localparam int AW    = 25;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [15:0]   din;
  } req_t;

  logic          clk = 1'b0;
  logic          res_n, dl_active, ld_wr, cart_rd;
  logic [AW-1:0] ld_addr, cart_addr, mem_addr;
  logic [7:0]    ld_data, cart_do;
  logic          cart_valid, mem_req, mem_we, mem_ack, busy, ovf, tmo;
  logic [15:0]   mem_din, mem_dout;

  cart_mem_arbiter #(.AW(AW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .res_n_i(res_n), .dl_active_i(dl_active),
    .ld_wr_i(ld_wr), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
    .cart_rd_i(cart_rd), .cart_addr_i(cart_addr),
    .cart_do_o(cart_do), .cart_valid_o(cart_valid),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_din_o(mem_din), .mem_dout_i(mem_dout), .mem_ack_i(mem_ack),
    .busy_o(busy), .ovf_o(ovf), .tmo_o(tmo)
  );

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_pass = 0;
  int            ack_lat = 3;
  bit            ack_en = 1'b1;
  bit            pend = 1'b0;
  int            cd = 0;
  req_t          preq;
  req_t          log_q[$];
  logic [7:0]    ram [logic [AW-1:0]];
  logic [AW-1:0] last_addr;
  logic [7:0]    last_do;

  function automatic logic [7:0] ram_rd(logic [AW-1:0] a);
    return ram.exists(a) ? ram[a] : (a[7:0] ^ 8'h3C);
  endfunction

  // SDRAM responder: sees requests at the falling edge, acks ack_lat cycles
  // later, commits writes on ack, returns junk in the unused high byte.
  initial begin
    mem_ack = 1'b0; mem_dout = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!res_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (cd <= 0) begin
            mem_ack = 1'b1;
            pend    = 1'b0;
            if (preq.we) begin
              ram[preq.addr] = preq.din[7:0];
              mem_dout = 16'($urandom);
            end else begin
              mem_dout = {8'($urandom), ram_rd(preq.addr)};
            end
          end else begin
            cd--;
          end
        end
        if (mem_req) begin
          preq = {mem_we, mem_addr, mem_din};
          log_q.push_back(preq);
          if (ack_en) begin pend = 1'b1; cd = ack_lat - 1; end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_idle(int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_req(int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (mem_req) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_valid(int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (cart_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    res_n = 1'b0; tick(2);
    n_chk++;
    if ({cart_do, cart_valid, mem_req, mem_we, mem_addr, mem_din, busy, ovf, tmo} !==
        {8'hFF, 3'b000, {AW{1'b0}}, 16'h0000, 3'b000})
      $display("FAIL reset_values: got do=%h v=%b req=%b we=%b a=%h din=%h busy=%b ovf=%b tmo=%b exp do=ff rest 0",
               cart_do, cart_valid, mem_req, mem_we, mem_addr, mem_din, busy, ovf, tmo);
    else n_pass++;
    res_n = 1'b1; tick(3);
    n_chk++;
    if ({busy, cart_do} !== {1'b0, 8'hFF})
      $display("FAIL reset_release: got busy=%b do=%h exp busy=0 do=ff", busy, cart_do);
    else n_pass++;
  endtask

  task automatic test_loader_burst();
    req_t exp[$];
    bit   ok;
    logic [7:0] d;
    dl_active = 1'b0; tick(); dl_active = 1'b1; tick();
    for (int pass = 0; pass < 2; pass++) begin
      log_q.delete(); exp.delete();
      ack_lat = (pass == 0) ? 3 : int'($urandom_range(1, 4));
      for (int i = 0; i < 8; i++) begin
        if (pass == 0 && i >= 4) break;
        ld_wr   = 1'b1;
        ld_addr = (pass == 0) ? AW'(i) : AW'($urandom);
        d       = (pass == 0) ? 8'(8'hA0 + i) : 8'($urandom);
        ld_data = d;
        exp.push_back({1'b1, ld_addr, d, d});
        tick(); ld_wr = 1'b0;
        tick(ack_lat + 2 + ((pass == 0) ? 1 : int'($urandom_range(0, 4))));
      end
      wait_idle(200, ok);
      n_chk++;
      if (!ok || log_q.size() != exp.size())
        $display("FAIL burst%0d_count: got %0d reqs (idle=%b) exp %0d", pass, log_q.size(), ok, exp.size());
      else n_pass++;
      for (int i = 0; i < exp.size(); i++) begin
        n_chk++;
        if (log_q[i] !== exp[i])
          $display("FAIL burst%0d_req%0d: got %h exp %h", pass, i, log_q[i], exp[i]);
        else n_pass++;
      end
      n_chk++;
      if (ovf !== 1'b0) $display("FAIL burst%0d_ovf: got %b exp 0", pass, ovf);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    bit ok;
    ack_en = 1'b0; log_q.delete();
    for (int i = 0; i < 6; i++) begin
      ld_wr = 1'b1; ld_addr = AW'(25'h100 + i); ld_data = 8'(8'h10 + i);
      tick();
    end
    ld_wr = 1'b0;
    n_chk++;
    if (ovf !== 1'b1) $display("FAIL ovf_set: got %b exp 1", ovf); else n_pass++;
    n_chk++;
    if (log_q.size() != 1) $display("FAIL ovf_inflight: got %0d reqs exp 1", log_q.size());
    else n_pass++;
    ack_en = 1'b1;
    wait_idle(1000, ok);
    n_chk++;
    if (!ok || log_q.size() != 5)
      $display("FAIL ovf_issued: got %0d reqs (idle=%b) exp 5", log_q.size(), ok);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (log_q[i] !== {1'b1, AW'(25'h100 + i), {2{8'(8'h10 + i)}}})
        $display("FAIL ovf_req%0d: got %h exp addr %h", i, log_q[i], 25'h100 + i);
      else n_pass++;
    end
    n_chk++;
    if (tmo !== 1'b1) $display("FAIL ovf_first_tmo: got %b exp 1", tmo); else n_pass++;
    dl_active = 1'b0; tick(); dl_active = 1'b1; tick();
    n_chk++;
    if ({ovf, tmo} !== 2'b00) $display("FAIL flags_clear: got ovf=%b tmo=%b exp 0 0", ovf, tmo);
    else n_pass++;
  endtask

  task automatic test_cart_read();
    bit ok;
    int n;
    dl_active = 1'b0; ack_lat = 2; ram[25'h123] = 8'h5A; ram[25'h124] = 8'hC3;
    log_q.delete(); tick();
    cart_addr = 25'h123; cart_rd = 1'b1;
    wait_req(20, ok); tick(4);
    n_chk++;
    if (!ok || log_q.size() != 1 || log_q[0].we !== 1'b0 || log_q[0].addr !== 25'h123)
      $display("FAIL rd_req: got n=%0d first=%h exp one read of 0123", log_q.size(), log_q[0]);
    else n_pass++;
    n_chk++;
    if ({cart_valid, cart_do} !== {1'b1, 8'h5A})
      $display("FAIL rd_data: got v=%b do=%h exp v=1 do=5a", cart_valid, cart_do);
    else n_pass++;
    tick(20);
    n_chk++;
    if (log_q.size() != 1) $display("FAIL rd_dedup: got %0d reqs exp 1", log_q.size());
    else n_pass++;
    ack_lat = 1;
    cart_addr = 25'h124; #1;
    n_chk++;
    if (cart_valid !== 1'b0) $display("FAIL rd_change_drop: got v=%b exp 0", cart_valid);
    else n_pass++;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); n++;
      if (cart_valid) break;
    end
    n_chk++;
    if (n != 3 || cart_do !== 8'hC3 || log_q.size() != 2)
      $display("FAIL rd_latency: got cycles=%0d do=%h reqs=%0d exp 3 c3 2", n, cart_do, log_q.size());
    else n_pass++;
  endtask

  task automatic test_read_random();
    logic [7:0]    vals[4];
    logic [AW-1:0] exp_a[$];
    logic [AW-1:0] prev, a;
    int            k;
    ack_lat = $urandom_range(1, 4);
    for (int i = 0; i < 4; i++) begin
      vals[i] = 8'($urandom); ram[AW'(25'h200 + i)] = vals[i];
    end
    log_q.delete(); prev = 25'h124;
    for (int s = 0; s < 12; s++) begin
      k = $urandom_range(0, 3);
      a = AW'(25'h200 + k);
      cart_addr = a;
      if (a != prev) exp_a.push_back(a);
      prev = a;
      tick(ack_lat + 4 + int'($urandom_range(0, 5)));
      n_chk++;
      if ({cart_valid, cart_do} !== {1'b1, vals[k]})
        $display("FAIL rnd_rd%0d: got v=%b do=%h exp v=1 do=%h (addr %h)", s, cart_valid, cart_do, vals[k], a);
      else n_pass++;
    end
    n_chk++;
    if (log_q.size() != exp_a.size())
      $display("FAIL rnd_rd_count: got %0d reqs exp %0d", log_q.size(), exp_a.size());
    else n_pass++;
    for (int i = 0; i < exp_a.size(); i++) begin
      n_chk++;
      if (log_q[i].we !== 1'b0 || log_q[i].addr !== exp_a[i])
        $display("FAIL rnd_rd_addr%0d: got %h exp read of %h", i, log_q[i], exp_a[i]);
      else n_pass++;
    end
    last_addr = prev;
  endtask

  task automatic test_priority();
    bit ok;
    int n_at_valid;
    logic [7:0] d;
    d = ~ram_rd(last_addr);
    ack_lat = 2; log_q.delete();
    dl_active = 1'b1; ld_wr = 1'b1; ld_addr = last_addr; ld_data = d;
    tick();
    ld_wr = 1'b0; dl_active = 1'b0;
    wait_valid(60, ok);
    n_at_valid = log_q.size();
    n_chk++;
    if (!ok || n_at_valid != 2)
      $display("FAIL prio_valid_gate: got valid=%b reqs_at_valid=%0d exp 1 2", ok, n_at_valid);
    else n_pass++;
    n_chk++;
    if (log_q[0] !== {1'b1, last_addr, d, d} || log_q[1] !== {1'b0, last_addr, log_q[0].din})
      $display("FAIL prio_order: got %h then %h exp write then read of %h", log_q[0], log_q[1], last_addr);
    else n_pass++;
    n_chk++;
    if (cart_do !== d) $display("FAIL prio_data: got %h exp %h", cart_do, d); else n_pass++;
  endtask

  task automatic test_write_during_read();
    bit ok;
    logic [AW-1:0] b;
    logic [7:0] e;
    b = AW'(25'h300 + $urandom_range(0, 15));
    ram[b] = 8'($urandom); e = ~ram[b];
    ack_lat = 3; log_q.delete();
    cart_addr = b;
    wait_req(20, ok);
    tick();
    ld_wr = 1'b1; ld_addr = b; ld_data = e;
    tick(); ld_wr = 1'b0;
    wait_valid(80, ok);
    n_chk++;
    if (!ok || log_q.size() != 3)
      $display("FAIL wdr_count: got valid=%b reqs=%0d exp 1 3", ok, log_q.size());
    else n_pass++;
    n_chk++;
    if (log_q[0].we !== 1'b0 || log_q[1] !== {1'b1, b, e, e} || log_q[2].we !== 1'b0 || log_q[2].addr !== b)
      $display("FAIL wdr_order: got %h %h %h exp R W R of %h", log_q[0], log_q[1], log_q[2], b);
    else n_pass++;
    n_chk++;
    if (cart_do !== e) $display("FAIL wdr_data: got %h exp %h", cart_do, e); else n_pass++;
    last_do = e;
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    logic [AW-1:0] c;
    c = 25'h400; ram[c] = 8'($urandom);
    ack_en = 1'b0; ack_lat = 2; log_q.delete();
    cart_addr = c;
    wait_req(20, ok);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tmo) break;
      n++;
    end
    n_chk++;
    if (!ok || n != TMO) $display("FAIL tmo_cycles: got %0d exp %0d", n, TMO); else n_pass++;
    n_chk++;
    if ({cart_valid, cart_do} !== {1'b0, last_do})
      $display("FAIL tmo_hold: got v=%b do=%h exp v=0 do=%h", cart_valid, cart_do, last_do);
    else n_pass++;
    ack_en = 1'b1;
    wait_valid(40, ok);
    n_chk++;
    if (!ok || log_q.size() != 2 || log_q[1].we !== 1'b0 || log_q[1].addr !== c || cart_do !== ram[c])
      $display("FAIL tmo_retry: got valid=%b reqs=%0d do=%h exp 1 2 %h", ok, log_q.size(), cart_do, ram[c]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    ack_en = 1'b0;
    cart_addr = 25'h500;
    wait_req(20, ok);
    tick(3);
    res_n = 1'b0; #1;
    n_chk++;
    if ({cart_do, cart_valid, mem_req, mem_we, mem_addr, mem_din, busy, ovf, tmo} !==
        {8'hFF, 3'b000, {AW{1'b0}}, 16'h0000, 3'b000})
      $display("FAIL reset_mid: got do=%h v=%b req=%b busy=%b ovf=%b tmo=%b exp do=ff rest 0 (req seen=%b)",
               cart_do, cart_valid, mem_req, busy, ovf, tmo, ok);
    else n_pass++;
    cart_rd = 1'b0;
    tick(2); res_n = 1'b1; tick(2);
    n_chk++;
    if ({busy, cart_valid, cart_do} !== {2'b00, 8'hFF})
      $display("FAIL reset_mid_release: got busy=%b v=%b do=%h exp 0 0 ff", busy, cart_valid, cart_do);
    else n_pass++;
    ack_en = 1'b1;
  endtask

  initial begin
    res_n = 1'b0; dl_active = 1'b0; ld_wr = 1'b0; ld_addr = '0; ld_data = '0;
    cart_rd = 1'b0; cart_addr = '0; last_addr = '0; last_do = 8'hFF;
    test_reset();
    test_loader_burst();
    test_overflow();
    test_cart_read();
    test_read_random();
    test_priority();
    test_write_during_read();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
